bp_cfg_boot_sequencer: RTL and testbench

Post-reset configuration sequencer that consumes the selected processor configuration (core count, boot PC, cache/CCE modes) and drives the ordered configuration-bus writes that bring every core tile out of freeze. It sits directly downstream of the parameter package. Its inputs are elaborated from the active `bp_proc_param_s`, and its output is the config link into the tiles' config registers. It enforces a credit limit on outstanding writes and signals completion to the testbench or host.

---
 rtl/bp_cfg_boot_sequencer.sv | 216 +++++++++++++++++++++
 tb/tb_bp_cfg_boot_sequencer.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/bp_cfg_boot_sequencer.sv
// Post-reset config sequencer: writes each core's config registers, unfreezes the cores, then signals done.
// Define BP_CFG_READBACK_EN to read FREEZE back from every core and flag any nonzero value on error_o.
module bp_cfg_boot_sequencer #(
    parameter int          num_core_p       = 1,
    parameter int          cfg_addr_width_p = 16,
    parameter int          cfg_data_width_p = 64,
    parameter int          max_credits_p    = 8,
    parameter logic [39:0] boot_pc_p        = 40'h0080000000,
    parameter int          did_p            = 0,
    localparam int core_id_width_lp = (num_core_p > 1) ? $clog2(num_core_p) : 1,
    localparam int credit_width_lp  = $clog2(max_credits_p + 1)
) (
    input  logic                        clk_i,
    input  logic                        reset_i,
    output logic                        cfg_v_o,
    output logic                        cfg_w_o,
    output logic [core_id_width_lp-1:0] cfg_core_o,
    output logic [cfg_addr_width_p-1:0] cfg_addr_o,
    output logic [cfg_data_width_p-1:0] cfg_data_o,
    input  logic                        cfg_ready_i,
    input  logic                        cfg_resp_v_i,
    input  logic [cfg_data_width_p-1:0] cfg_resp_data_i,
    output logic                        cfg_resp_yumi_o,
    output logic                        done_o,
    output logic                        error_o
);

    localparam logic [cfg_addr_width_p-1:0] ADDR_FREEZE = cfg_addr_width_p'(16'h0001);
    localparam logic [cfg_addr_width_p-1:0] ADDR_CORE   = cfg_addr_width_p'(16'h0002);
    localparam logic [cfg_addr_width_p-1:0] ADDR_DID    = cfg_addr_width_p'(16'h0003);
    localparam logic [cfg_addr_width_p-1:0] ADDR_ICACHE = cfg_addr_width_p'(16'h0010);
    localparam logic [cfg_addr_width_p-1:0] ADDR_DCACHE = cfg_addr_width_p'(16'h0011);
    localparam logic [cfg_addr_width_p-1:0] ADDR_CCE    = cfg_addr_width_p'(16'h0020);
    localparam logic [cfg_addr_width_p-1:0] ADDR_NPC    = cfg_addr_width_p'(16'h0030);
    localparam logic [credit_width_lp-1:0]  CREDIT_MAX  = credit_width_lp'(max_credits_p);
    localparam logic [core_id_width_lp-1:0] LAST_CORE   = core_id_width_lp'(num_core_p - 1);
    localparam logic [2:0]                  LAST_IDX    = 3'd6;

    typedef enum logic [2:0] {
        e_reset,
        e_write_cfg,
        e_drain,
        e_unfreeze,
`ifdef BP_CFG_READBACK_EN
        e_readback,
`endif
        e_done_drain,
        e_done
    } state_e;

    state_e                      r_state;
    logic [core_id_width_lp-1:0] r_core;
    logic [2:0]                  r_idx;
    logic [credit_width_lp-1:0]  r_credits;

    logic                        w_issue;
    logic                        w_v;
    logic                        w_hs;
    logic                        w_resp_ok;
    logic                        w_last_core;
    logic [credit_width_lp-1:0]  w_credits_nxt;
    logic                        w_w;
    logic [core_id_width_lp-1:0] w_core;
    logic [cfg_addr_width_p-1:0] w_addr;
    logic [cfg_data_width_p-1:0] w_data;

    // e_reset issues the first FREEZE write so the request is up in the first cycle out of reset
    always_comb begin
        w_issue = 1'b0;
        unique case (r_state)
            e_reset, e_write_cfg, e_unfreeze: w_issue = ~reset_i;
`ifdef BP_CFG_READBACK_EN
            e_readback:                       w_issue = ~reset_i;
`endif
            default:                          w_issue = 1'b0;
        endcase
    end

    assign w_v           = w_issue & (r_credits != CREDIT_MAX);
    assign w_hs          = w_v & cfg_ready_i;
    assign w_resp_ok     = cfg_resp_v_i & (r_credits != '0);
    assign w_last_core   = (r_core == LAST_CORE);
    assign w_credits_nxt = r_credits + credit_width_lp'(w_hs) - credit_width_lp'(w_resp_ok);

    always_comb begin
        w_w    = 1'b0;
        w_core = '0;
        w_addr = '0;
        w_data = '0;
        if (w_issue) begin
            w_w    = 1'b1;
            w_core = r_core;
            unique case (r_state)
                e_reset, e_write_cfg: begin
                    unique case (r_idx)
                        3'd0:    begin w_addr = ADDR_FREEZE; w_data = cfg_data_width_p'(1);         end
                        3'd1:    begin w_addr = ADDR_CORE;   w_data = cfg_data_width_p'(r_core);    end
                        3'd2:    begin w_addr = ADDR_DID;    w_data = cfg_data_width_p'(did_p);     end
                        3'd3:    begin w_addr = ADDR_ICACHE; w_data = cfg_data_width_p'(1);         end
                        3'd4:    begin w_addr = ADDR_DCACHE; w_data = cfg_data_width_p'(1);         end
                        3'd5:    begin w_addr = ADDR_CCE;    w_data = cfg_data_width_p'(1);         end
                        default: begin w_addr = ADDR_NPC;    w_data = cfg_data_width_p'(boot_pc_p); end
                    endcase
                end
                e_unfreeze: w_addr = ADDR_FREEZE;
`ifdef BP_CFG_READBACK_EN
                e_readback: begin
                    w_w    = 1'b0;
                    w_addr = ADDR_FREEZE;
                end
`endif
                default: w_addr = '0;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            r_state   <= e_reset;
            r_core    <= '0;
            r_idx     <= '0;
            r_credits <= '0;
        end else begin
            r_credits <= w_credits_nxt;
            unique case (r_state)
                e_reset, e_write_cfg: begin
                    r_state <= e_write_cfg;
                    if (w_hs) begin
                        if (r_idx == LAST_IDX) begin
                            r_idx <= '0;
                            if (w_last_core) begin
                                r_core  <= '0;
                                r_state <= e_drain;
                            end else begin
                                r_core <= r_core + 1'b1;
                            end
                        end else begin
                            r_idx <= r_idx + 3'd1;
                        end
                    end
                end
                e_drain: if (r_credits == '0) r_state <= e_unfreeze;
                e_unfreeze: begin
                    if (w_hs) begin
                        if (w_last_core) begin
                            r_core  <= '0;
`ifdef BP_CFG_READBACK_EN
                            r_state <= e_readback;
`else
                            r_state <= e_done_drain;
`endif
                        end else begin
                            r_core <= r_core + 1'b1;
                        end
                    end
                end
`ifdef BP_CFG_READBACK_EN
                e_readback: begin
                    if (w_hs) begin
                        if (w_last_core) begin
                            r_core  <= '0;
                            r_state <= e_done_drain;
                        end else begin
                            r_core <= r_core + 1'b1;
                        end
                    end
                end
`endif
                // Look at the next count so done follows the final response by one cycle
                e_done_drain: if (w_credits_nxt == '0) r_state <= e_done;
                e_done:       r_state <= e_done;
                default:      r_state <= e_reset;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (!reset_i) begin
            assert (!(cfg_resp_v_i && (r_credits == '0)));
        end
    end

`ifdef BP_CFG_READBACK_EN
    localparam int resp_cnt_width_lp = $clog2(9 * num_core_p + 1);
    localparam logic [resp_cnt_width_lp-1:0] READ_BASE = resp_cnt_width_lp'(8 * num_core_p);

    logic [resp_cnt_width_lp-1:0] r_resp_cnt;
    logic                         r_error;

    // Responses return in order and every read follows every write, so the response index identifies reads
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            r_resp_cnt <= '0;
            r_error    <= 1'b0;
        end else if (w_resp_ok) begin
            r_resp_cnt <= r_resp_cnt + 1'b1;
            if ((r_resp_cnt >= READ_BASE) && (cfg_resp_data_i != '0)) r_error <= 1'b1;
        end
    end

    assign error_o = r_error;
`else
    logic w_unused_resp_data;
    assign w_unused_resp_data = ^cfg_resp_data_i;
    assign error_o            = 1'b0;
`endif

    assign cfg_v_o         = w_v;
    assign cfg_w_o         = w_w;
    assign cfg_core_o      = w_core;
    assign cfg_addr_o      = w_addr;
    assign cfg_data_o      = w_data;
    assign cfg_resp_yumi_o = cfg_resp_v_i;
    assign done_o          = (r_state == e_done);

endmodule

// File: tb/tb_bp_cfg_boot_sequencer.sv
// Bench for bp_cfg_boot_sequencer: a driver issues ready/response stimulus, a monitor checks every
// request and per-cycle status against an ordered expected-request list built from the register table.
module tb_bp_cfg_boot_sequencer;

    localparam int          N      = 3;
    localparam int          AW     = 16;
    localparam int          DW     = 64;
    localparam int          MAXC   = 3;
    localparam int          DID    = 5;
    localparam logic [39:0] BOOT   = 40'h0080000000;
    localparam int          CW     = 2;
`ifdef BP_CFG_READBACK_EN
    localparam int          RB     = 1;
`else
    localparam int          RB     = 0;
`endif
    localparam int          TOTAL  = (8 + RB) * N;

    logic          clk = 1'b0;
    logic          reset_i = 1'b1;
    logic          cfg_v_o, cfg_w_o, cfg_ready_i, cfg_resp_v_i, cfg_resp_yumi_o, done_o, error_o;
    logic [CW-1:0] cfg_core_o;
    logic [AW-1:0] cfg_addr_o;
    logic [DW-1:0] cfg_data_o, cfg_resp_data_i;

    always #5 clk = ~clk;

    bp_cfg_boot_sequencer #(
        .num_core_p(N), .cfg_addr_width_p(AW), .cfg_data_width_p(DW),
        .max_credits_p(MAXC), .boot_pc_p(BOOT), .did_p(DID)
    ) dut (
        .clk_i(clk), .reset_i(reset_i),
        .cfg_v_o(cfg_v_o), .cfg_w_o(cfg_w_o), .cfg_core_o(cfg_core_o),
        .cfg_addr_o(cfg_addr_o), .cfg_data_o(cfg_data_o), .cfg_ready_i(cfg_ready_i),
        .cfg_resp_v_i(cfg_resp_v_i), .cfg_resp_data_i(cfg_resp_data_i),
        .cfg_resp_yumi_o(cfg_resp_yumi_o), .done_o(done_o), .error_o(error_o)
    );

    typedef struct { logic w; int core; logic [15:0] addr; logic [63:0] data; } req_t;
    typedef struct { int due; logic [63:0] data; } rsp_t;

    req_t exp_q[$];
    rsp_t pend[$];
    logic kind_q[$];
    int   checks = 0, errors = 0;
    int   cyc = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference sequence: seven config writes per core, one unfreeze per core, optional readbacks
    function automatic void push_sequence();
        int reg_addr[7];
        reg_addr = '{'h1, 'h2, 'h3, 'h10, 'h11, 'h20, 'h30};
        exp_q.delete();
        for (int c = 0; c < N; c++) begin
            for (int r = 0; r < 7; r++) begin
                logic [63:0] d;
                case (r)
                    0:       d = 64'd1;
                    1:       d = 64'(c);
                    2:       d = 64'(DID);
                    6:       d = 64'(BOOT);
                    default: d = 64'd1;
                endcase
                exp_q.push_back('{1'b1, c, 16'(reg_addr[r]), d});
            end
        end
        for (int c = 0; c < N; c++) exp_q.push_back('{1'b1, c, 16'h1, 64'd0});
`ifdef BP_CFG_READBACK_EN
        for (int c = 0; c < N; c++) exp_q.push_back('{1'b0, c, 16'h1, 64'd0});
`endif
    endfunction

    // ---------------- monitor ----------------
    logic prev_rst = 1'b1, stall_prev = 1'b0, err_exp = 1'b0, chk_b2b = 1'b0;
    int   rel_cyc = 0, hs_idx = 0, retired = 0, done_cyc = -1, reads_seen = 0, last_wr_rsp = -1;
    req_t held;

    always begin
        @(negedge clk);
        #2;
        if (reset_i) begin
            if (prev_rst) begin
                check("rst_v", cfg_v_o, 0);
                check("rst_done", done_o, 0);
                check("rst_error", error_o, 0);
                check("rst_addr", cfg_addr_o, 0);
                check("rst_data", cfg_data_o, 0);
                check("rst_core", cfg_core_o, 0);
                check("rst_w", cfg_w_o, 0);
            end
            check("rst_yumi", cfg_resp_yumi_o, cfg_resp_v_i);
            hs_idx = 0; retired = 0; done_cyc = -1; err_exp = 1'b0; stall_prev = 1'b0;
            reads_seen = 0; last_wr_rsp = -1;
            kind_q.delete();
        end else begin
            logic err_next;
            err_next = 1'b0;
            if (prev_rst) rel_cyc = cyc;
            check("yumi", cfg_resp_yumi_o, cfg_resp_v_i);
            check("done", done_o, (done_cyc >= 0) && (cyc >= done_cyc));
            check("error", error_o, err_exp);
            if (stall_prev) begin
                check("stall_v", cfg_v_o, 1);
                check("stall_w", cfg_w_o, held.w);
                check("stall_core", cfg_core_o, held.core);
                check("stall_addr", cfg_addr_o, held.addr);
                check("stall_data", cfg_data_o, held.data);
            end
            if (cfg_resp_v_i) begin
                if (kind_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL resp_orphan: response with no outstanding request (cycle %0d)", cyc);
                end else begin
                    logic k;
                    k = kind_q.pop_front();
                    if (!k && cfg_resp_data_i != 0) err_next = 1'b1;
                end
                retired++;
                if (retired == 7 * N) last_wr_rsp = cyc;
                if (retired == TOTAL) done_cyc = cyc + 1;
            end
            if (cfg_v_o && cfg_ready_i) begin
                if (exp_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL extra_req: got core %0d addr 0x%0h, expected none", cfg_core_o, cfg_addr_o);
                end else begin
                    req_t e;
                    e = exp_q.pop_front();
                    check("req_w", cfg_w_o, e.w);
                    check("req_core", cfg_core_o, e.core);
                    check("req_addr", cfg_addr_o, e.addr);
                    check("req_data", cfg_data_o, e.data);
                    kind_q.push_back(e.w);
                    if (!e.w) reads_seen++;
                    if (chk_b2b && hs_idx < 7 * N) check("b2b_cycle", cyc - rel_cyc, hs_idx);
                    if (chk_b2b && hs_idx == 7 * N) check("unfreeze_gap", cyc, last_wr_rsp + 2);
                end
                hs_idx++;
            end
            stall_prev = cfg_v_o && !cfg_ready_i;
            held = '{cfg_w_o, int'(cfg_core_o), cfg_addr_o, cfg_data_o};
            err_exp = err_exp | err_next;
        end
        prev_rst = reset_i;
    end

    // ---------------- driver ----------------
    int   rdy_pct = 100, lat_min = 2, lat_max = 2, bad_core = -1, rel_n = 0, drv_hs = 0;
    logic withhold = 1'b0, rst_req = 1'b1;

    task automatic step();
        @(negedge clk);
        cyc++;
        if (reset_i && !rst_req) push_sequence();
        reset_i = rst_req;
        if (rst_req) begin
            pend.delete();
            drv_hs = 0;
        end
        cfg_ready_i     = (rdy_pct >= 100) || ($urandom_range(99) < rdy_pct);
        cfg_resp_v_i    = 1'b0;
        cfg_resp_data_i = {$urandom, $urandom};
        if (reset_i) begin
            cfg_resp_v_i = 1'($urandom_range(1));
        end else if (pend.size() > 0 && pend[0].due <= cyc && (!withhold || rel_n > 0)) begin
            cfg_resp_v_i    = 1'b1;
            cfg_resp_data_i = pend[0].data;
            void'(pend.pop_front());
            if (rel_n > 0) rel_n--;
        end
        #1;
        if (!reset_i && cfg_v_o && cfg_ready_i) begin
            rsp_t r;
            r.due  = cyc + int'($urandom_range(lat_max, lat_min));
            r.data = {$urandom, $urandom};
            if (!cfg_w_o) r.data = (int'(cfg_core_o) == bad_core) ? 64'h1 : 64'h0;
            pend.push_back(r);
            drv_hs++;
        end
    endtask

    task automatic reset_pulse(input int n);
        rst_req = 1'b1;
        repeat (n) step();
        rst_req = 1'b0;
    endtask

    task automatic run_done(input int budget);
        int n;
        n = 0;
        while (!done_o && n < budget) begin
            step();
            n++;
        end
        check("done_reached", done_o, 1);
        repeat (3) step();
        check("all_issued", exp_q.size(), 0);
    endtask

    initial begin
        int n;
        cfg_ready_i = 1'b0; cfg_resp_v_i = 1'b0; cfg_resp_data_i = '0;

        // Full speed with 2-cycle responses: back-to-back writes and exact drain/done timing
        reset_pulse(4);
        chk_b2b = 1'b1;
        run_done(300);
        chk_b2b = 1'b0;

        // Withheld responses: issue stops at the credit limit and resumes after one response
        reset_pulse(2);
        withhold = 1'b1;
        repeat (8) step();
        check("credit_stall_hs", drv_hs, MAXC);
        check("credit_stall_v", cfg_v_o, 0);
        rel_n = 1;
        step();
        check("resp_released", cfg_resp_v_i, 1);
        check("still_stalled", cfg_v_o, 0);
        step();
        check("resume_after_resp", cfg_v_o, 1);
        withhold = 1'b0;
        run_done(300);

        // Random backpressure and response latency
        rdy_pct = 50; lat_min = 1; lat_max = 4;
        repeat (3) begin
            reset_pulse(2);
            run_done(3000);
        end

        // Reset while core 2, reg 3 is pending
        reset_pulse(2);
        n = 0;
        while (drv_hs < 2 * 7 + 3 && n < 2000) begin
            step();
            n++;
        end
        check("reached_core2_reg3", drv_hs, 17);
        reset_pulse(2);
        run_done(3000);

        // Core 1 readback returns nonzero
        rdy_pct = 100; lat_min = 1; lat_max = 3; bad_core = 1;
        reset_pulse(2);
        run_done(500);
        check("readback_error", error_o, RB);
        check("reads_seen", reads_seen, RB * N);
        check("done_final", done_o, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, checks %0d errors %0d", checks, errors);
        $fatal(1);
    end

endmodule
